// File: rtl/pixel_fb_writer.sv
// Plots a clipped (x,y,ink) pixel stream into a 1-bpp byte-wide framebuffer RAM
// using read-modify-write, with a 4-entry input FIFO and a flush handshake.
module pixel_fb_writer #(
   parameter int unsigned FB_W   = 64,
   parameter int unsigned FB_H   = 64,
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        x_in,
   input  logic [7:0]        y_in,
   input  logic              ink_in,
   input  logic              pixel_valid,
   output logic              pixel_ready,
   input  logic              shape_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [7:0]        mem_rdata,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              flush_done,
   output logic              overflow,
   output logic [7:0]        clip_count
);

   localparam int unsigned DEPTH     = 4;
   localparam int unsigned PTR_W     = 2;
   localparam int unsigned CNT_W     = 3;
   localparam int unsigned ENT_W     = 17;
   localparam int unsigned ROW_BYTES = FB_W / 8;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_WR} state_t;

   state_t             state;
   logic [ENT_W-1:0]   fifo [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_nxt;
   logic               in_win;
   logic               full;
   logic               push;
   logic               pop;
   logic [ENT_W-1:0]   head;
   logic [ADDR_W-1:0]  head_addr;
   logic [2:0]         bit_idx;
   logic               ink;
   logic               pending;
   logic [7:0]         mod_byte;

   // Entry layout: {x[7:0], y[7:0], ink}; a pop frees a slot for a same-cycle push.
   always_comb begin
      in_win    = (32'(x_in) < FB_W) && (32'(y_in) < FB_H);
      full      = (count == CNT_W'(DEPTH));
      pop       = (state == S_IDLE) && (count != '0);
      push      = pixel_valid && in_win && (!full || pop);
      count_nxt = count + CNT_W'(push) - CNT_W'(pop);
      head      = fifo[rd_ptr];
      head_addr = ADDR_W'(32'(head[8:1]) * ROW_BYTES + 32'(head[16:12]));
      mod_byte  = mem_rdata;
      mod_byte[bit_idx] = ink;
   end

   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= {x_in, y_in, ink_in};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         pixel_ready <= 1'b1;
         busy        <= 1'b0;
         overflow    <= 1'b0;
         clip_count  <= '0;
         flush_done  <= 1'b0;
         pending     <= 1'b0;
         mem_addr    <= '0;
         mem_rd_en   <= 1'b0;
         mem_wr_en   <= 1'b0;
         mem_wdata   <= '0;
         bit_idx     <= '0;
         ink         <= 1'b0;
      end else begin
         count       <= count_nxt;
         pixel_ready <= (count_nxt != CNT_W'(DEPTH));
         busy        <= (count_nxt != '0) || pop || (state == S_RD) || (state == S_WAIT);
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (pixel_valid && in_win && !push) overflow <= 1'b1;
         if (pixel_valid && !in_win && (clip_count != 8'hFF))
            clip_count <= clip_count + 8'd1;

         // Done is deferred until nothing is queued, in flight, or arriving.
         flush_done <= 1'b0;
         if (pending && (count == '0) && (state == S_IDLE) && !push) begin
            flush_done <= 1'b1;
            pending    <= 1'b0;
         end else if (shape_done) begin
            pending <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (pop) begin
                  mem_addr  <= head_addr;
                  bit_idx   <= head[11:9];
                  ink       <= head[0];
                  mem_rd_en <= 1'b1;
                  state     <= S_RD;
               end
            end
            S_RD: begin
               mem_rd_en <= 1'b0;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               mem_wdata <= mod_byte;
               mem_wr_en <= 1'b1;
               state     <= S_WR;
            end
            S_WR: begin
               mem_wr_en <= 1'b0;
               mem_wdata <= '0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed and randomized checks of pixel_fb_writer against a queue/server
// reference model of the framebuffer writer and a behavioural RAM.
module tb_pixel_fb_writer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] x_in;
   logic [7:0] y_in;
   logic       ink_in;
   logic       pixel_valid;
   logic       pixel_ready;
   logic       shape_done;
   logic [8:0] mem_addr;
   logic       mem_rd_en;
   logic [7:0] mem_rdata;
   logic       mem_wr_en;
   logic [7:0] mem_wdata;
   logic       busy;
   logic       flush_done;
   logic       overflow;
   logic [7:0] clip_count;

   always #5 clk = ~clk;

   pixel_fb_writer #(.FB_W(64), .FB_H(64), .ADDR_W(9)) dut (
      .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in), .ink_in(ink_in),
      .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .shape_done(shape_done),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
      .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .busy(busy),
      .flush_done(flush_done), .overflow(overflow), .clip_count(clip_count)
   );

   // Behavioural RAM: registered read data, write visible to the next read.
   logic [7:0] ram [512];
   logic       ram_clr;
   logic       pre_we;
   logic [8:0] pre_addr;
   logic [7:0] pre_data;

   always @(posedge clk) begin
      if (ram_clr) for (int i = 0; i < 512; i++) ram[i] <= 8'h00;
      if (pre_we) ram[pre_addr] <= pre_data;
      if (mem_wr_en) ram[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= ram[mem_addr];
   end

   // Reference model: a 4-slot queue feeding a server that needs 4 cycles per pixel.
   logic [16:0] mq[$];
   int          srv;
   logic [16:0] wk;
   logic        pending_m, ovf_m, flush_m, rd_m, wr_m;
   int          clip_m;
   logic [8:0]  addr_m;
   logic [7:0]  wdata_m;
   logic [7:0]  fb_m [512];

   int n_vec = 0;
   int n_miss = 0;

   function automatic int baddr(input logic [16:0] p);
      return int'(p[8:1]) * 8 + int'(p[16:9]) / 8;
   endfunction

   function automatic logic [7:0] modb(input logic [7:0] b, input logic [16:0] p);
      logic [7:0] r;
      r = b;
      r[p[11:9]] = p[0];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic v, input logic [7:0] x, input logic [7:0] y,
                             input logic k, input logic sd, input logic r);
      int   sz;
      logic inwin, pop, acc;
      if (r) begin
         mq.delete();
         srv = 0; pending_m = 0; ovf_m = 0; clip_m = 0; flush_m = 0;
         rd_m = 0; wr_m = 0; addr_m = '0; wdata_m = '0;
         return;
      end
      sz    = mq.size();
      inwin = (x < 8'd64) && (y < 8'd64);
      pop   = (srv == 0) && (sz > 0);
      acc   = v && inwin && (sz < 4 || pop);
      if (v && !inwin && clip_m < 255) clip_m++;
      if (v && inwin && !acc) ovf_m = 1;
      flush_m = pending_m && (sz == 0) && (srv == 0) && !acc;
      if (flush_m) pending_m = 0;
      else if (sd) pending_m = 1;
      if (pop) begin
         wk = mq.pop_front();
         srv = 3;
         addr_m = 9'(baddr(wk));
      end else if (srv > 0) begin
         if (srv == 1) fb_m[baddr(wk)] = modb(fb_m[baddr(wk)], wk);
         srv--;
      end
      if (acc) mq.push_back({x, y, k});
      rd_m    = (srv == 3);
      wr_m    = (srv == 1);
      wdata_m = wr_m ? modb(fb_m[baddr(wk)], wk) : 8'h00;
   endtask

   task automatic check_all();
      chk("pixel_ready", 32'(pixel_ready), 32'(mq.size() < 4));
      chk("busy", 32'(busy), 32'(mq.size() > 0 || srv > 0));
      chk("flush_done", 32'(flush_done), 32'(flush_m));
      chk("overflow", 32'(overflow), 32'(ovf_m));
      chk("clip_count", 32'(clip_count), 32'(clip_m));
      chk("mem_rd_en", 32'(mem_rd_en), 32'(rd_m));
      chk("mem_wr_en", 32'(mem_wr_en), 32'(wr_m));
      chk("mem_addr", 32'(mem_addr), 32'(addr_m));
      chk("mem_wdata", 32'(mem_wdata), 32'(wdata_m));
   endtask

   // One clock: drive at the falling edge, advance the model, check after the next fall.
   task automatic cyc(input logic v, input logic [7:0] x, input logic [7:0] y,
                      input logic k, input logic sd, input logic r);
      pixel_valid = v; x_in = x; y_in = y; ink_in = k; shape_done = sd; rst = r;
      model_step(v, x, y, k, sd, r);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++) cyc(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (busy && n < 200) begin
         idle(1);
         n++;
      end
      chk("drain_timeout", 32'(busy), 32'(0));
   endtask

   task automatic preload(input logic [8:0] a, input logic [7:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      fb_m[a] = d;
      idle(1);
      pre_we = 1'b0;
   endtask

   initial begin
      logic v;
      pixel_valid = 0; x_in = 0; y_in = 0; ink_in = 0; shape_done = 0; rst = 1;
      pre_we = 0; pre_addr = '0; pre_data = '0; ram_clr = 1;
      for (int i = 0; i < 512; i++) fb_m[i] = 8'h00;
      @(negedge clk);
      do_reset();
      ram_clr = 0;
      chk("reset_ready", 32'(pixel_ready), 32'(1));
      chk("reset_busy", 32'(busy), 32'(0));

      // Single pixel (9,2) -> byte 17 bit 1, write 4 cycles after the push.
      cyc(1'b1, 8'd9, 8'd2, 1'b1, 1'b0, 1'b0);
      idle(1);
      chk("t1_rd", 32'({mem_rd_en, mem_addr}), 32'({1'b1, 9'd17}));
      idle(2);
      chk("t1_wr", 32'({mem_wr_en, mem_addr, mem_wdata}), 32'({1'b1, 9'd17, 8'h02}));
      idle(1);
      cyc(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
      idle(1);
      chk("t1_flush", 32'(flush_done), 32'(1));
      cyc(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
      chk("t1_flush_single", 32'(flush_done), 32'(0));
      idle(3);
      chk("t1_ram17", 32'(ram[17]), 32'(8'h02));

      // Burst along row 0 honouring pixel_ready.
      for (int i = 0; i < 8; i++) begin
         int n;
         n = 0;
         while (!pixel_ready && n < 50) begin idle(1); n++; end
         cyc(1'b1, 8'(i), 8'd0, 1'b1, 1'b0, 1'b0);
      end
      drain();
      idle(1);
      chk("t2_byte0", 32'(ram[0]), 32'(8'hFF));
      chk("t2_no_overflow", 32'(overflow), 32'(0));

      // Same burst ignoring pixel_ready: pixels 6 and 7 are dropped.
      do_reset();
      preload(9'd0, 8'h00);
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 8'd0, 1'b1, 1'b0, 1'b0);
      drain();
      idle(1);
      chk("t3_byte0", 32'(ram[0]), 32'(8'h3F));
      chk("t3_overflow", 32'(overflow), 32'(1));

      // Clipping and saturation of clip_count.
      do_reset();
      cyc(1'b1, 8'd64, 8'd0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 8'd0, 8'd64, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 8'd255, 8'd255, 1'b1, 1'b0, 1'b0);
      idle(1);
      chk("t4_clip3", 32'(clip_count), 32'(3));
      chk("t4_no_access", 32'({busy, mem_rd_en, mem_wr_en, overflow}), 32'(0));
      for (int i = 0; i < 297; i++) cyc(1'b1, 8'd255, 8'($urandom), 1'b0, 1'b0, 1'b0);
      chk("t4_clip_sat", 32'(clip_count), 32'(255));

      // Clear a pixel in a full byte.
      do_reset();
      preload(9'd0, 8'hFF);
      cyc(1'b1, 8'd3, 8'd0, 1'b0, 1'b0, 1'b0);
      drain();
      idle(1);
      chk("t5_byte0", 32'(ram[0]), 32'(8'hF7));

      // Reset while the read data is being captured aborts the write.
      do_reset();
      cyc(1'b1, 8'd5, 8'd1, 1'b1, 1'b0, 1'b0);
      idle(2);
      cyc(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
      chk("t6_outs", 32'({pixel_ready, busy, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0}));
      idle(6);
      chk("t6_ram8", 32'(ram[8]), 32'(8'h00));

      // Randomized traffic, first honouring pixel_ready, then ignoring it.
      for (int i = 0; i < 1200; i++) begin
         v = 1'($urandom);
         if (i < 600) v = v & pixel_ready;
         cyc(v, 8'($urandom_range(0, 79)), 8'($urandom_range(0, 79)), 1'($urandom),
             1'($urandom_range(0, 39) == 0), 1'b0);
      end
      drain();
      idle(2);
      for (int i = 0; i < 512; i++) chk($sformatf("fb[%0d]", i), 32'(ram[i]), 32'(fb_m[i]));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
